// File: rtl/iomem_dbg_master.sv
// Byte-stream debug initiator: 'W'/'R' command frames become single 32-bit iomem transactions.
// Define IOMEM_DBG_TIMEOUT_EN to build the BUS watchdog (answers 'T' after TIMEOUT cycles).
module iomem_dbg_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t      state, state_d;
  logic [1:0]  byte_cnt, byte_cnt_d;
  logic        is_write, is_write_d;
  logic [31:0] addr_d, wdata_d;
  logic [31:0] resp, resp_d;
  logic [2:0]  resp_cnt, resp_cnt_d;
  logic        rx_fire, tx_fire, expired;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign tx_data = resp[7:0];

`ifdef IOMEM_DBG_TIMEOUT_EN
  logic [15:0] wdog;

  // Counts completed BUS cycles; zero on the first BUS cycle.
  always_ff @(posedge clk) begin
    if (!resetn || state != BUS) wdog <= '0;
    else                         wdog <= wdog + 16'd1;
  end

  assign expired = (wdog == 16'(TIMEOUT - 1));
`else
  // No watchdog in this build; the parameter stays for a uniform interface.
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    is_write_d = is_write;
    addr_d     = iomem_addr;
    wdata_d    = iomem_wdata;
    resp_d     = resp;
    resp_cnt_d = resp_cnt;
    case (state)
      IDLE: if (rx_fire) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          is_write_d = (rx_data == 8'h57);
          byte_cnt_d = '0;
          state_d    = ADDR;
        end else begin
          resp_d     = 32'h0000_003F;
          resp_cnt_d = 3'd1;
          state_d    = RESP;
        end
      end
      ADDR: if (rx_fire) begin
        addr_d     = {rx_data, iomem_addr[31:8]};
        byte_cnt_d = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) state_d = is_write ? WDATA : BUS;
      end
      WDATA: if (rx_fire) begin
        wdata_d    = {rx_data, iomem_wdata[31:8]};
        byte_cnt_d = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) state_d = BUS;
      end
      BUS: begin
        // A completion in the expiry cycle still counts as a normal completion.
        if (iomem_valid && iomem_ready) begin
          resp_d     = is_write ? 32'h0000_004B : iomem_rdata;
          resp_cnt_d = is_write ? 3'd1 : 3'd4;
          state_d    = RESP;
        end else if (expired) begin
          resp_d     = 32'h0000_0054;
          resp_cnt_d = 3'd1;
          state_d    = RESP;
        end
      end
      RESP: if (tx_fire) begin
        resp_d     = {8'h00, resp[31:8]};
        resp_cnt_d = resp_cnt - 3'd1;
        if (resp_cnt == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      is_write    <= 1'b0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      resp        <= '0;
      resp_cnt    <= '0;
      rx_ready    <= 1'b0;
      tx_valid    <= 1'b0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'h0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      byte_cnt    <= byte_cnt_d;
      is_write    <= is_write_d;
      iomem_addr  <= addr_d;
      iomem_wdata <= wdata_d;
      resp        <= resp_d;
      resp_cnt    <= resp_cnt_d;
      // Handshake outputs are decoded from the next state so they stay registered.
      rx_ready    <= (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
      tx_valid    <= (state_d == RESP);
      iomem_valid <= (state_d == BUS);
      iomem_wstrb <= (state_d == BUS && is_write_d) ? 4'hF : 4'h0;
      busy        <= (state_d != IDLE);
    end
  end
endmodule
